// File: rtl/mod_reduct_solinas2_pipe.sv
// Pipelined reduction of a double-width product modulo 2^W - 2^K + 1.
// Two folding stages use 2^W == 2^K - 1 (mod p); a final stage subtracts up to 3*p.
module mod_reduct_solinas2_pipe #(
    parameter int         MOD_W    = 64,
    parameter int         INT_POW  = 32,
    parameter int         IN_W     = 128,
    parameter bit         IN_PIPE  = 1'b1,
    parameter int         SIDE_W   = 0,
    parameter logic [1:0] RST_SIDE = 2'b00
) (
    input  logic                                  clk,
    input  logic                                  a_rst_n,
    input  logic [IN_W-1:0]                       a,
    input  logic                                  in_avail,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    output logic [MOD_W-1:0]                      z,
    output logic                                  out_avail,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

    localparam int SW   = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int P1   = IN_PIPE ? 1 : 0;
    localparam int NS   = P1 + 3;
    localparam int X_W  = 2 * MOD_W;
    localparam int T1_W = MOD_W + INT_POW + 1;
    localparam int T2_W = MOD_W + 2;
    localparam logic [T2_W-1:0] ONE    = 1;
    localparam logic [T2_W-1:0] MOD_T2 = (ONE << MOD_W) - (ONE << INT_POW) + ONE;

    genvar gi;

    generate
        if (INT_POW < 1 || INT_POW > MOD_W / 2) begin : g_bad_int_pow
            $error("INT_POW must satisfy 1 <= INT_POW <= MOD_W/2");
        end
        if (IN_W <= MOD_W || IN_W > 2 * MOD_W) begin : g_bad_in_w
            $error("IN_W must satisfy MOD_W < IN_W <= 2*MOD_W");
        end
    endgenerate

    // Valid/side chain: index i is the avail/side entering pipeline register i.
    logic [NS:0]   w_av_chain;
    logic [SW-1:0] w_side_chain [NS+1];

    assign w_av_chain[0]   = in_avail;
    assign w_side_chain[0] = in_side;

    generate
        for (gi = 0; gi < NS; gi++) begin : g_stage
            logic          r_av;
            logic [SW-1:0] r_side;

            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) r_av <= 1'b0;
                else          r_av <= w_av_chain[gi];
            end

            if (RST_SIDE != 2'b00) begin : g_side_rst
                always_ff @(posedge clk or negedge a_rst_n) begin
                    if (!a_rst_n) r_side <= RST_SIDE[0] ? '0 : '1;
                    else          r_side <= w_side_chain[gi];
                end
            end else begin : g_side_free
                always_ff @(posedge clk) begin
                    r_side <= w_side_chain[gi];
                end
            end

            assign w_av_chain[gi+1]   = r_av;
            assign w_side_chain[gi+1] = r_side;
        end
    endgenerate

    // Optional input register
    logic [IN_W-1:0] w_x_in;

    generate
        if (IN_PIPE) begin : g_in_reg
            logic [IN_W-1:0] r_a;
            always_ff @(posedge clk) begin
                if (in_avail) r_a <= a;
            end
            assign w_x_in = r_a;
        end else begin : g_in_comb
            assign w_x_in = a;
        end
    endgenerate

    // Stage 1: fold the upper word, x = xl + xh*(2^K - 1)
    logic [X_W-1:0]   w_x;
    logic [MOD_W-1:0] w_xl;
    logic [MOD_W-1:0] w_xh;
    logic [T1_W-1:0]  w_t1;
    logic [T1_W-1:0]  r_t1;

    assign w_x  = X_W'(w_x_in);
    assign w_xl = w_x[MOD_W-1:0];
    assign w_xh = w_x[X_W-1:MOD_W];
    assign w_t1 = T1_W'(w_xl) + (T1_W'(w_xh) << INT_POW) - T1_W'(w_xh);

    always_ff @(posedge clk) begin
        if (w_av_chain[P1]) r_t1 <= w_t1;
    end

    // Stage 2: second fold of the K+1 bit overflow
    logic [INT_POW:0] w_t1h;
    logic [MOD_W-1:0] w_t1l;
    logic [T2_W-1:0]  w_t2;
    logic [T2_W-1:0]  r_t2;

    assign w_t1h = r_t1[T1_W-1:MOD_W];
    assign w_t1l = r_t1[MOD_W-1:0];
    assign w_t2  = T2_W'(w_t1l) + (T2_W'(w_t1h) << INT_POW) - T2_W'(w_t1h);

    always_ff @(posedge clk) begin
        if (w_av_chain[P1+1]) r_t2 <= w_t2;
    end

    // Stage 3: t2 < 4*p, so pick the largest j in 0..3 with t2 >= j*p
    logic [2:0]       w_ge;
    logic [MOD_W-1:0] w_c [1:3];
    logic [MOD_W-1:0] w_z;
    logic [MOD_W-1:0] r_z;

    generate
        for (gi = 1; gi <= 3; gi++) begin : g_cand
            localparam logic [T2_W-1:0] MOD_J = T2_W'(gi) * MOD_T2;
            assign w_ge[gi-1] = (r_t2 >= MOD_J);
            assign w_c[gi]    = r_t2[MOD_W-1:0] - MOD_J[MOD_W-1:0];
        end
    endgenerate

    always_comb begin
        w_z = r_t2[MOD_W-1:0];
        for (int j = 1; j <= 3; j++) begin
            if (w_ge[j-1]) w_z = w_c[j];
        end
    end

    always_ff @(posedge clk) begin
        if (w_av_chain[P1+2]) r_z <= w_z;
    end

    assign z         = r_z;
    assign out_avail = w_av_chain[NS];
    assign out_side  = w_side_chain[NS];

endmodule

// File: doc/mod_reduct_solinas2_pipe.md
Name: mod_reduct_solinas2_pipe

Overview:
- Fixed-latency pipelined modular reduction stage sitting directly downstream of the constant multiplier.
- Consumes the full-width product z (up to 2*MOD_W bits) and returns the product reduced modulo a Solinas2 prime MOD = 2^MOD_W - 2^INT_POW + 1 (Goldilocks when MOD_W=64, INT_POW=32).
- Carries the same avail/side sideband as the multiplier, so the two chain without glue logic.

Parameters:
- MOD_W, 64, modulus width W.
- INT_POW, 32, middle exponent K; legal range 1 <= K <= W/2; out-of-range values fail elaboration.
- IN_W, 128, input width; legal range W < IN_W <= 2*W; input is zero-extended to 2*W internally.
- IN_PIPE, 1'b1, 1 = register inputs before stage 1.
- SIDE_W, 0, side data width; 0 = unused.
- RST_SIDE, 2'b00, side reset value: [0]=1 resets side to 0, [1]=1 resets side to 1, 00 = side registers not reset.

Ports:
- clk  in  1  clock.
- a_rst_n  in  1  reset, asynchronous, active-low.
- a  in  IN_W  product to reduce.
- in_avail  in  1  a/in_side valid this cycle.
- in_side  in  SIDE_W  side data travelling with a.
- z  out  MOD_W  a mod MOD, range [0, MOD-1].
- out_avail  out  1  z/out_side valid.
- out_side  out  SIDE_W  side data aligned with z.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset a_rst_n.
- No backpressure. Every in_avail=1 cycle yields exactly one out_avail=1 cycle LAT = IN_PIPE + 3 cycles later. in_avail=0 produces bubbles in the same positions. Full throughput of 1 result per cycle; no internal state other than the pipeline.
- Reset:
  - All avail flops clear to 0 asynchronously, so out_avail=0 during and immediately after reset.
  - Data path flops (including z) are not reset; z is don't-care while out_avail=0.
  - Side flops follow RST_SIDE.
  - Assertion mid-stream drops all in-flight items; no spurious out_avail after release.
- Data flops load only when the stage avail is 1 (clock-enable); side flops load every cycle with the stage avail.
- Stage 0 (optional IN_PIPE): register a, in_avail, in_side.
- Stage 1: x = {xh, xl}, xl = x[W-1:0], xh = x[2W-1:W].
  - Compute t1 = xl + (xh << K) - xh, held in W+K+1 bits; always non-negative.
  - Uses the identity 2^W == 2^K - 1 mod MOD. Registered.
- Stage 2: t1 = {t1h, t1l}, t1h of K+1 bits.
  - Compute t2 = t1l + (t1h << K) - t1h, held in W+2 bits. Bound: t2 < 3*2^W, so t2 < 4*MOD.
  - Registered.
- Stage 3: compute c_j = t2 - j*MOD for j = 1, 2, 3 in parallel (W+3 bit signed).
  - Select the largest j with c_j >= 0 (c_0 = t2).
  - Register the result into z[W-1:0] and raise out_avail.
- Result must equal a mod MOD for every a < 2^IN_W, including a = 0, a = multiples of MOD, and a = 2^IN_W - 1.
- Width rules: no truncation anywhere before stage 3; z holds exactly MOD_W bits.

Test Plan (MOD_W=64, INT_POW=32, IN_PIPE=1, SIDE_W=8, MOD=0xFFFFFFFF00000001, LAT=4):
- Single a=0, side=0xA5 -> out_avail pulses once, 4 cycles later, z=0, out_side=0xA5.
- Edge values, issued back-to-back:
  - a=MOD -> z=0.
  - a=2^64 -> z=0x00000000FFFFFFFF.
  - a=(MOD-1)^2 -> z=1.
  - a=2^128-1 -> z=0xFFFFFFFE00000000.
  - Outputs appear on 4 consecutive cycles, in order.
- 10k random 128-bit a, in_avail randomly 0/1 (50%), side = sequence counter -> each z matches the reference model a mod MOD; out_avail pattern equals in_avail delayed by 4; side counters are in order with no gaps or duplicates.
- Rerun with IN_PIPE=0 -> latency exactly 3, same results.
- Reset corner: assert a_rst_n low asynchronously (mid-cycle) while 3 items are in flight -> out_avail drops to 0 immediately; with RST_SIDE=2'b01, out_side=0; no output for pre-reset items after release; the first post-reset item (a=5) yields z=5 after 4 cycles.
- Parameter corner: MOD_W=32, INT_POW=16, IN_W=48, a=2^48-1 -> z equals (2^48-1) mod (2^32-2^16+1) per the reference model; also a=2^32 -> z=0xFFFF.
